uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Sequencer between the UART transmit FIFO and the UART transmitter. When enabled and the FIFO is non-empty, it pops one byte, captures it, and launches one transmitter frame. It then waits for frame completion and enforces an optional inter-frame gap. It also counts sent frames and flags transmitter stalls with a watchdog.

## Interface
- DATA_WIDTH, 8, byte width; matches FIFO and transmitter.
- GAP_CYCLES, 0, idle cycles inserted after each completed frame; 0 = none.
- TIMEOUT_CYCLES, 0, watchdog limit in cycles spent waiting for tx_done; 0 = watchdog disabled.
- CNT_WIDTH, 16, width of sent_count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  permit starting new frames.
- clear_err  in  1  clears tx_error; takes effect on the next edge.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd  out  1  one-cycle pop strobe to the FIFO.
- fifo_r_data  in  DATA_WIDTH  FIFO registered read data; valid the cycle after fifo_rd.
- tx_start  out  1  one-cycle frame-launch pulse.
- tx_data  out  DATA_WIDTH  byte for the transmitter; registered.
- tx_done  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- busy  out  1  high in every state except IDLE.
- tx_error  out  1  sticky watchdog flag.
- sent_count  out  CNT_WIDTH  number of completed frames; wraps modulo 2^CNT_WIDTH.

## Operation
- The FSM has six states: IDLE, POP, LOAD, START, WAIT_DONE, GAP.
- **IDLE**
  - If enable=1 and fifo_empty=0, go to POP; otherwise stay.
  - enable and fifo_empty are sampled only here.
- **POP**
  - fifo_rd=1 for this cycle only.
  - Always go to LOAD.
- **LOAD**
  - Capture fifo_r_data into tx_data.
  - Go to START.
- **START**
  - tx_start=1 for this cycle only; tx_data already holds the captured byte.
  - Clear the watchdog counter.
  - Go to WAIT_DONE.
- **WAIT_DONE**
  - On tx_done=1: increment sent_count, then go to GAP if GAP_CYCLES>0, else to IDLE.
  - Otherwise increment the watchdog counter. With TIMEOUT_CYCLES>0, the counter reaching TIMEOUT_CYCLES (that many WAIT_DONE cycles without tx_done) sets tx_error=1. The FSM then leaves WAIT_DONE exactly as for tx_done, except that sent_count is not incremented.
- **GAP**
  - Count GAP_CYCLES cycles, then go to IDLE.
- tx_data holds its value from LOAD until the next LOAD.
- fifo_rd and tx_start are decoded from the state register only: glitch-free, exactly one cycle per frame.
- tx_done is ignored outside WAIT_DONE, including a tx_done coincident with tx_start.
- tx_done and the watchdog limit in the same cycle: tx_done wins; no error, count increments.
- enable deasserted mid-frame: the current frame runs to completion (through GAP). No new pop occurs until enable=1 in IDLE.
- fifo_rd is never asserted while fifo_empty=1 was sampled in IDLE.
- tx_error is sticky; only clear_err or reset clears it.
- clear_err and a new timeout in the same cycle: tx_error stays set.
- The FSM keeps running while tx_error=1.
- sent_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Counters are sized internally to hold GAP_CYCLES and TIMEOUT_CYCLES.
- **Reset** (any state, including mid-frame):
  - Next edge: state=IDLE, fifo_rd=0, tx_start=0, tx_data=0, busy=0, tx_error=0, sent_count=0, and both internal counters cleared.
  - A popped byte in flight is discarded.
  - A later tx_done for an aborted frame is ignored.

## Timing
- Let cycle 0 be an IDLE cycle with enable=1 and fifo_empty=0:
  - cycle 1: fifo_rd=1;
  - cycle 2: tx_data loads;
  - cycle 3: tx_start=1 with valid tx_data.
- busy rises in cycle 1.
- tx_done seen in WAIT_DONE at cycle D: sent_count updates at cycle D+1.
  - GAP occupies D+1 .. D+GAP_CYCLES; IDLE at D+GAP_CYCLES+1.
  - With GAP_CYCLES=0, IDLE at D+1.
- Minimum frame-to-frame spacing, tx_start to tx_start: frame length + GAP_CYCLES + 4 cycles.
- Watchdog: WAIT_DONE entered at cycle W. The error transition is taken at cycle W+TIMEOUT_CYCLES-1; tx_error=1 visible from W+TIMEOUT_CYCLES.

## Test plan
Unless a scenario says otherwise, DATA_WIDTH=8, GAP_CYCLES=2, TIMEOUT_CYCLES=20.
- **Single byte:** FIFO holds 0xA5, enable=1 at cycle 0; transmitter model pulses tx_done at cycle 10.
  - fifo_rd only at cycle 1.
  - tx_start only at cycle 3, with tx_data=0xA5.
  - sent_count=1 at cycle 11.
  - busy=0 at cycle 13.
- **Burst:** FIFO preloaded with 0x01, 0x02, 0x03, enable held high.
  - Three tx_start pulses carrying 0x01, 0x02, 0x03 in order.
  - Exactly three fifo_rd pulses, none while empty.
  - sent_count=3; busy=0 afterwards.
- **Enable drop:** enable=0 during WAIT_DONE of the first byte, with 2 bytes remaining in the FIFO.
  - The current frame completes and sent_count=1.
  - No fifo_rd until enable=1; re-enabling sends the remaining 2 bytes.
- **Watchdog:** tx_done withheld.
  - tx_error=1 exactly 20 cycles after WAIT_DONE entry; sent_count unchanged.
  - The next byte is still sent.
  - clear_err=1 returns tx_error to 0 on the next edge.
- **Reset mid-frame:** reset asserted during WAIT_DONE, then tx_done pulsed after reset release.
  - All outputs 0 one edge after reset.
  - sent_count stays 0; no tx_start until the FIFO is non-empty again.
- **Count wrap:** CNT_WIDTH=4, 16 frames sent.
  - sent_count reads 15 after frame 15 and 0 after frame 16.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: pops FIFO bytes and launches UART frames, with inter-frame gap, sent-frame count and tx_done watchdog
module uart_tx_scheduler #(
  parameter int DATA_WIDTH     = 8,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear_err,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  tx_error,
  output logic [CNT_WIDTH-1:0]  sent_count
);
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, WAIT_DONE, GAP} state_t;
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  state_t state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] wd_q, wd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic timeout;
  assign timeout = (TIMEOUT_CYCLES > 0) && state_q == WAIT_DONE && !tx_done && wd_q == WD_LAST;
  assign fifo_rd = state_q == POP;
  assign tx_start = state_q == START;
  assign busy = state_q != IDLE;
  assign tx_data = data_q;
  assign tx_error = err_q;
  assign sent_count = cnt_q;
  always_comb begin
    state_d = state_q;
    gap_d = gap_q;
    wd_d = wd_q;
    data_d = data_q;
    cnt_d = cnt_q;
    err_d = timeout | (err_q & ~clear_err);
    case (state_q)
      IDLE: state_d = enable && !fifo_empty ? POP : IDLE;
      POP: state_d = LOAD;
      LOAD: begin
        data_d = fifo_r_data;
        state_d = START;
      end
      START: begin
        wd_d = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        wd_d = wd_q + 1'b1;
        cnt_d = tx_done ? cnt_q + 1'b1 : cnt_q;
        gap_d = '0;
        state_d = tx_done || timeout ? (GAP_CYCLES > 0 ? GAP : IDLE) : WAIT_DONE;
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        state_d = gap_q == GAP_LAST ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gap_q <= '0;
      wd_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q <= gap_d;
      wd_q <= wd_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: randomized and directed bench with a frame-timeline reference model
module tb_uart_tx_scheduler;
  localparam int GAP = 2;
  localparam int TO = 20;
  localparam int CW = 4;
  logic clk = 0;
  logic reset = 1;
  logic enable = 0;
  logic clear_err = 0;
  logic fifo_empty = 1;
  logic tx_done = 0;
  logic [7:0] fifo_r_data = 0;
  logic fifo_rd, tx_start, busy, tx_error;
  logic [7:0] tx_data;
  logic [CW-1:0] sent_count;
  int n_chk = 0;
  int n_err = 0;
  logic [7:0] fifo_q[$];
  int lat_mode = 0;
  int cd = 0;
  uart_tx_scheduler #(.DATA_WIDTH(8), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear_err(clear_err), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .fifo_r_data(fifo_r_data), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy), .tx_error(tx_error), .sent_count(sent_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      if (n_err <= 50) $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // reference model: a frame is a timeline counted from its pop cycle (rel=1)
  bit m_act = 0;
  int m_rel = 0;
  int m_exit = 0;
  bit m_to = 0;
  logic [7:0] m_byte = 0;
  logic [7:0] m_data = 0;
  logic [CW-1:0] m_cnt = 0;
  bit m_err = 0;
  initial forever begin
    @(negedge clk);
    chk("fifo_rd", fifo_rd, m_act && m_rel == 1);
    chk("tx_start", tx_start, m_act && m_rel == 3);
    chk("busy", busy, m_act);
    chk("tx_data", tx_data, m_data);
    chk("sent_count", sent_count, m_cnt);
    chk("tx_error", tx_error, m_err);
    if (reset) begin
      m_act = 0; m_rel = 0; m_exit = 0; m_data = 0; m_cnt = 0; m_err = 0;
    end else begin
      m_to = 0;
      if (!m_act) begin
        if (enable && !fifo_empty) begin
          m_act = 1; m_rel = 1; m_exit = 0; m_byte = fifo_q[0];
        end
      end else begin
        if (m_rel == 2) m_data = m_byte;
        if (m_rel >= 4 && m_exit == 0) begin
          if (tx_done) begin
            m_cnt = m_cnt + 1'b1;
            m_exit = m_rel;
          end else if (m_rel - 3 == TO) begin
            m_to = 1;
            m_exit = m_rel;
          end
        end
        if (m_exit != 0 && m_rel >= m_exit + GAP) m_act = 0;
        else m_rel++;
      end
      m_err = m_to | (m_err & !clear_err);
    end
  end
  task automatic step();
    bit pop;
    pop = fifo_rd;
    @(posedge clk);
    #1;
    tx_done = 0;
    clear_err = 0;
    if (pop && fifo_q.size() > 0) fifo_r_data = fifo_q.pop_front();
    fifo_empty = fifo_q.size() == 0;
    if (tx_start && lat_mode >= 0) cd = lat_mode > 0 ? lat_mode : $urandom_range(1, 24);
    else if (cd > 0) begin
      cd--;
      if (cd == 0) tx_done = 1;
    end
  endtask
  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    enable = 0;
    step();
    step();
    reset = 0;
    cd = 0;
  endtask
  task automatic wait_start();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      ok = tx_start;
    end
    chk("wait_start", ok, 1);
  endtask
  initial begin
    int rds, bad, dn;
    bit pd, ok;
    logic [7:0] got[$];
    do_reset();
    lat_mode = 7;
    push(8'hA5);
    enable = 1;
    chk("sb_rd_c0", fifo_rd, 0);
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 1) begin chk("sb_rd_c1", fifo_rd, 1); chk("sb_busy_c1", busy, 1); end
      if (c == 2) chk("sb_rd_c2", fifo_rd, 0);
      if (c == 3) begin chk("sb_start_c3", tx_start, 1); chk("sb_data_c3", tx_data, 8'hA5); end
      if (c == 10) chk("sb_cnt_c10", sent_count, 0);
      if (c == 11) chk("sb_cnt_c11", sent_count, 1);
      if (c == 12) chk("sb_busy_c12", busy, 1);
      if (c == 13) chk("sb_busy_c13", busy, 0);
    end
    do_reset();
    lat_mode = 5;
    push(8'h01); push(8'h02); push(8'h03);
    enable = 1;
    rds = 0; bad = 0; got.delete();
    for (int i = 0; i < 80; i++) begin
      step();
      if (tx_start) got.push_back(tx_data);
      if (fifo_rd) rds++;
      if (fifo_rd && fifo_empty) bad++;
    end
    chk("burst_starts", got.size(), 3);
    chk("burst_d0", got[0], 8'h01);
    chk("burst_d1", got[1], 8'h02);
    chk("burst_d2", got[2], 8'h03);
    chk("burst_rds", rds, 3);
    chk("burst_rd_empty", bad, 0);
    chk("burst_cnt", sent_count, 3);
    chk("burst_busy", busy, 0);
    do_reset();
    lat_mode = 6;
    push(8'h31); push(8'h32); push(8'h33);
    enable = 1;
    wait_start();
    step();
    enable = 0;
    rds = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (fifo_rd) rds++;
    end
    chk("drop_rds", rds, 0);
    chk("drop_cnt", sent_count, 1);
    chk("drop_busy", busy, 0);
    enable = 1;
    got.delete();
    for (int i = 0; i < 80; i++) begin
      step();
      if (tx_start) got.push_back(tx_data);
    end
    chk("drop_starts", got.size(), 2);
    chk("drop_d0", got[0], 8'h32);
    chk("drop_d1", got[1], 8'h33);
    chk("drop_cnt_end", sent_count, 3);
    do_reset();
    lat_mode = -1;
    push(8'h11); push(8'h22);
    enable = 1;
    wait_start();
    repeat (20) step();
    chk("wd_err_early", tx_error, 0);
    step();
    chk("wd_err_set", tx_error, 1);
    chk("wd_cnt", sent_count, 0);
    lat_mode = 4;
    wait_start();
    chk("wd_next_data", tx_data, 8'h22);
    repeat (10) step();
    chk("wd_next_cnt", sent_count, 1);
    chk("wd_sticky", tx_error, 1);
    clear_err = 1;
    step();
    chk("wd_clear", tx_error, 0);
    do_reset();
    lat_mode = -1;
    push(8'h5A);
    enable = 1;
    wait_start();
    repeat (3) step();
    reset = 1;
    step();
    reset = 0;
    chk("rst_rd", fifo_rd, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", tx_error, 0);
    chk("rst_cnt", sent_count, 0);
    tx_done = 1;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tx_start) ok = 1;
    end
    chk("rst_no_start", ok, 0);
    chk("rst_cnt_after", sent_count, 0);
    do_reset();
    lat_mode = 3;
    for (int i = 0; i < 16; i++) push(8'(i + 8'h40));
    enable = 1;
    dn = 0; pd = 0;
    for (int i = 0; i < 600 && dn < 16; i++) begin
      step();
      if (pd) begin
        dn++;
        if (dn == 15) chk("wrap_15", sent_count, 15);
        if (dn == 16) chk("wrap_16", sent_count, 0);
      end
      pd = tx_done;
    end
    chk("wrap_frames", dn, 16);
    do_reset();
    lat_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      reset = $urandom_range(0, 399) == 0;
      enable = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 19) == 0) clear_err = 1;
      if ($urandom_range(0, 9) == 0) push(8'($urandom));
      if ($urandom_range(0, 29) == 0) tx_done = 1;
    end
    reset = 0;
    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
